shiftrows_pipe: RTL and testbench
=================================

SHIFTROWS_PIPE -- requirements
Module: shiftrows_pipe

Interface
REQ-001 Parameter NB, default 4: state width in 32-bit columns; legal values 4, 6, 8 (Rijndael block sizes).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream block present.
REQ-005 in_ready  output  1  block able to accept; transfer when in_valid && in_ready.
REQ-006 in_data  input  32*NB  state, column-major, byte k = row k%4, column k/4, at bits [32*NB-1-8k -: 8].
REQ-007 in_inv  input  1  0 = forward ShiftRows, 1 = inverse ShiftRows; sampled with in_data.
REQ-008 in_last  input  1  sideband flag, passed through unchanged with its block.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-011 out_data  output  32*NB  permuted state, same byte layout as in_data.
REQ-012 out_last  output  1  in_last of the block on out_data.

Function
REQ-013 Row offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
REQ-014 Forward: out(r,c) = in(r,(c+s(r)) mod NB); inverse: out(r,(c+s(r)) mod NB) = in(r,c); row 0 never moves.
REQ-015 Permutation applied combinationally to in_data at acceptance; only permuted result and in_last stored.
REQ-016 Storage: one output register (main) plus one skid register; out_* driven from main only.
REQ-017 Latency: block accepted in cycle N appears on out_* in cycle N+1 at the earliest.
REQ-018 Throughput: one block per cycle sustained while out_ready held high.
REQ-019 in_ready is a register output equal to "skid empty"; no combinational path from out_ready to in_ready.
REQ-020 Accept with main empty, or main draining this cycle and skid empty -> write main.
REQ-021 Accept with main full and not draining -> write skid; in_ready low from next cycle.
REQ-022 Main draining with skid full -> skid moves to main, skid empties, in_ready high next cycle.
REQ-023 While out_valid && !out_ready, out_data and out_last hold stable.
REQ-024 Blocks leave in acceptance order; none dropped or duplicated; mode may change every block.
REQ-025 NB outside {4,6,8} -> elaboration-time error.

Reset
REQ-026 rst high at a clock edge: out_valid=0, skid empty, in_ready=1 on the following cycle; out_data and out_last = 0.
REQ-027 Reset mid-operation discards main and skid contents; no block accepted in a reset cycle.

Structure
REQ-028 Shared package aes_pkg holds the byte width constant, the legal-NB check and a function returning s(r) for a given NB.
REQ-029 Permutation lives in one combinational sub-module, rijndael_row_perm (parameter NB, inputs state and inv, output state); shiftrows_pipe holds only the handshake and storage.

Verification
REQ-030 NB=4, inv=0, in_data=000102030405060708090a0b0c0d0e0f -> one cycle later out_data=00050a0f04090e03080d02070c01060b.
REQ-031 NB=4, inv=1, in_data=000102030405060708090a0b0c0d0e0f -> out_data=000d0a0704010e0b0805020f0c090603; feeding back the REQ-030 result returns the original input.
REQ-032 NB=6 and NB=8 builds, random states, forward then inverse -> identity; row 3 of NB=8 shifted by 4 columns versus a software model.
REQ-033 out_ready=0 for 3 cycles, in_valid=1 with 3 blocks -> two blocks stored, in_ready=0 after the second, out_data stable; release -> blocks emerge in order, in_ready=1 one cycle after skid empties.
REQ-034 Random in_valid/out_ready, 1000 blocks, alternating inv and in_last -> scoreboard matches, zero loss, full rate when out_ready=1.
REQ-035 rst asserted with main and skid full -> next cycle out_valid=0, in_ready=1, old blocks never appear.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael constants and helpers used by the ShiftRows pipeline.
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int ROWS   = 4;

  // Rijndael block sizes supported by the row permutation.
  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Row rotation amount; the 256-bit block shifts rows 2 and 3 one column further.
  function automatic int row_shift(input int nb, input int r);
    if ((nb == 8) && (r >= 2)) begin
      return r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rijndael_row_perm.sv
// Combinational Rijndael ShiftRows / InvShiftRows byte permutation.
// Byte k sits at row k%4, column k/4, MSB-first in the state vector.
module rijndael_row_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state,
  input  logic             inv,
  output logic [32*NB-1:0] permuted
);

  localparam int W = 32 * NB;

  // Every destination byte picks one of two fixed source bytes, so the
  // whole permutation reduces to a 2:1 mux per byte.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      localparam int SHIFT   = row_shift(NB, gi);
      localparam int FWD_COL = (gj + SHIFT) % NB;
      localparam int INV_COL = (gj + NB - SHIFT) % NB;
      localparam int DST_K   = ROWS * gj + gi;
      localparam int FWD_K   = ROWS * FWD_COL + gi;
      localparam int INV_K   = ROWS * INV_COL + gi;

      assign permuted[W-1-BYTE_W*DST_K -: BYTE_W] =
        inv ? state[W-1-BYTE_W*INV_K -: BYTE_W]
            : state[W-1-BYTE_W*FWD_K -: BYTE_W];
    end
  end

endmodule

// File: rtl/shiftrows_pipe.sv
// Valid/ready pipeline stage applying ShiftRows (or its inverse) at acceptance.
// A main output register plus one skid register lets in_ready be a pure
// register, breaking any combinational path from out_ready to in_ready.
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic             out_last
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] permuted;
  logic         main_valid_reg;
  logic [W-1:0] main_data_reg;
  logic         main_last_reg;
  logic         skid_valid_reg;
  logic [W-1:0] skid_data_reg;
  logic         skid_last_reg;
  logic         in_ready_reg;
  logic         accept;
  logic         drain;

  rijndael_row_perm #(.NB(NB)) u_perm (
    .state    (in_data),
    .inv      (in_inv),
    .permuted (permuted)
  );

  assign accept = in_valid && in_ready_reg;
  assign drain  = main_valid_reg && out_ready;

  // Main/skid storage and the registered in_ready (always equal to "skid empty").
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else if (skid_valid_reg) begin
      // in_ready is low here, so nothing new arrives; only refill main.
      if (drain) begin
        main_data_reg  <= skid_data_reg;
        main_last_reg  <= skid_last_reg;
        skid_valid_reg <= 1'b0;
        in_ready_reg   <= 1'b1;
      end
    end else if (accept) begin
      if (!main_valid_reg || drain) begin
        main_valid_reg <= 1'b1;
        main_data_reg  <= permuted;
        main_last_reg  <= in_last;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= permuted;
        skid_last_reg  <= in_last;
        in_ready_reg   <= 1'b0;
      end
    end else if (drain) begin
      main_valid_reg <= 1'b0;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign out_last  = main_last_reg;

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Self-checking bench for shiftrows_pipe: NB=4 scoreboard plus NB=6/NB=8 instances.
module tb_shiftrows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // NB=4 instance
  logic         in_valid, in_ready, in_inv, in_last;
  logic         out_valid, out_ready, out_last;
  logic [127:0] in_data, out_data;

  // NB=6 and NB=8 instances share handshake inputs
  logic         w_in_valid, w_in_inv, w_in_last, w_out_ready;
  logic         w6_in_ready, w6_out_valid, w6_out_last;
  logic         w8_in_ready, w8_out_valid, w8_out_last;
  logic [191:0] w6_in_data, w6_out_data;
  logic [255:0] w8_in_data, w8_out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [128:0] sb_q[$];

  shiftrows_pipe #(.NB(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  shiftrows_pipe #(.NB(6)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w6_in_ready), .in_data(w6_in_data),
    .in_inv(w_in_inv), .in_last(w_in_last),
    .out_valid(w6_out_valid), .out_ready(w_out_ready),
    .out_data(w6_out_data), .out_last(w6_out_last)
  );

  shiftrows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data),
    .in_inv(w_in_inv), .in_last(w_in_last),
    .out_valid(w8_out_valid), .out_ready(w_out_ready),
    .out_data(w8_out_data), .out_last(w8_out_last)
  );

  // Reference ShiftRows: state occupies the low 32*nb bits of d.
  function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
    logic [7:0]   b [0:31];
    logic [255:0] o;
    int s, src;
    o = '0;
    for (int k = 0; k < 4 * nb; k++) b[k] = d[32*nb-1-8*k -: 8];
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c + nb - s) % nb : (c + s) % nb;
        o[32*nb-1-8*(4*c+r) -: 8] = b[4*src+r];
      end
    end
    return o;
  endfunction

  // Scoreboard: push on every input transfer, pop and compare on every output transfer.
  logic [255:0] mon_m;
  logic [128:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        mon_m = model(4, {128'b0, in_data}, in_inv);
        sb_q.push_back({in_last, mon_m[127:0]});
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_out++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected got=%b_%h want=none", out_last, out_data);
        end else begin
          mon_e = sb_q.pop_front();
          if ({out_last, out_data} !== mon_e) begin
            n_bad++;
            $display("FAIL sb_data got=%b_%h want=%b_%h", out_last, out_data, mon_e[128], mon_e[127:0]);
          end else begin
            $display("out block last=%b data=%h", out_last, out_data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_data !== 128'h0) begin n_bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    n_cmp++; if (w8_in_ready !== 1'b1 || w8_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_nb8 got=%b%b want=10", w8_in_ready, w8_out_valid); end
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    // forward
    in_data = 128'h000102030405060708090a0b0c0d0e0f; in_inv = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_latency got=%b want=1", out_valid); end
    n_cmp++; if (out_data !== 128'h00050a0f04090e03080d02070c01060b) begin n_bad++; $display("FAIL fwd_vector got=%h want=00050a0f04090e03080d02070c01060b", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL fwd_last got=%b want=1", out_last); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_drained got=%b want=0", out_valid); end
    // inverse
    in_inv = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n_cmp++; if (out_data !== 128'h000d0a0704010e0b0805020f0c090603) begin n_bad++; $display("FAIL inv_vector got=%h want=000d0a0704010e0b0805020f0c090603", out_data); end
    @(posedge clk); #1;
    // inverse of forward result returns the original
    in_data = 128'h00050a0f04090e03080d02070c01060b; in_inv = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n_cmp++; if (out_data !== 128'h000102030405060708090a0b0c0d0e0f) begin n_bad++; $display("FAIL inv_roundtrip got=%h want=000102030405060708090a0b0c0d0e0f", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_rate();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_inv = i[0]; in_last = i[1]; in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rate_in_ready i=%0d got=%b want=1", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rate_out_valid i=%0d got=%b want=1", i, out_valid); end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rate_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, c;
    logic [255:0] ma, mb;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    ma = model(4, {128'b0, a}, 1'b0);
    mb = model(4, {128'b0, b}, 1'b1);
    out_ready = 1'b0;
    in_data = a; in_inv = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = b; in_inv = 1'b1; in_last = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    in_data = c; in_inv = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_data !== ma[127:0] || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold i=%0d got=%b_%h want=1_%h", i, out_valid, out_data, ma[127:0]); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_low i=%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_data !== mb[127:0]) begin n_bad++; $display("FAIL release_second got=%h want=%h", out_data, mb[127:0]); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL release_pending got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_random();
    int start_out, sent, cyc, cyc2;
    logic took;
    start_out = n_out; sent = 0; cyc = 0; cyc2 = 0;
    in_valid = 1'b0;
    fork
      begin
        while (sent < 1000 && cyc < 30000) begin
          if (!in_valid && ($urandom_range(3) != 0)) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_inv = sent[0]; in_last = sent[1]; in_valid = 1'b1;
          end
          @(negedge clk); took = in_valid && in_ready;
          @(posedge clk); #1; cyc++;
          if (took) begin sent++; in_valid = 1'b0; end
        end
        in_valid = 1'b0;
      end
      begin
        while ((n_out - start_out) < 1000 && cyc2 < 30000) begin
          out_ready = ($urandom_range(3) != 0);
          @(posedge clk); #1; cyc2++;
        end
        out_ready = 1'b1;
      end
    join
    n_cmp++; if (sent != 1000) begin n_bad++; $display("FAIL random_sent got=%0d want=1000", sent); end
    n_cmp++; if ((n_out - start_out) != 1000) begin n_bad++; $display("FAIL random_received got=%0d want=1000", n_out - start_out); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL random_pending got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_full got=%b%b want=01", in_ready, out_valid); end
    rst = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_data !== 128'h0) begin n_bad++; $display("FAIL rstmid_out_data got=%h want=0", out_data); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ghost i=%0d got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_wide();
    logic [255:0] d8, e8, f8, e6;
    logic [191:0] d6, f6;
    w_out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      e8 = model(8, d8, 1'b0);
      e6 = model(6, {64'b0, d6}, 1'b0);
      w8_in_data = d8; w6_in_data = d6; w_in_inv = 1'b0; w_in_last = t[0]; w_in_valid = 1'b1;
      @(posedge clk); #1; w_in_valid = 1'b0;
      n_cmp++; if (w8_out_valid !== 1'b1 || w8_out_data !== e8) begin n_bad++; $display("FAIL nb8_fwd t=%0d got=%h want=%h", t, w8_out_data, e8); end
      n_cmp++; if (w6_out_valid !== 1'b1 || w6_out_data !== e6[191:0]) begin n_bad++; $display("FAIL nb6_fwd t=%0d got=%h want=%h", t, w6_out_data, e6[191:0]); end
      n_cmp++; if (w8_out_data[255-8*3 -: 8] !== d8[255-8*19 -: 8]) begin n_bad++; $display("FAIL nb8_row3 t=%0d got=%h want=%h", t, w8_out_data[255-8*3 -: 8], d8[255-8*19 -: 8]); end
      n_cmp++; if (w8_out_last !== t[0]) begin n_bad++; $display("FAIL nb8_last t=%0d got=%b want=%b", t, w8_out_last, t[0]); end
      f8 = w8_out_data; f6 = w6_out_data;
      @(posedge clk); #1;
      w8_in_data = f8; w6_in_data = f6; w_in_inv = 1'b1; w_in_valid = 1'b1;
      @(posedge clk); #1; w_in_valid = 1'b0;
      n_cmp++; if (w8_out_data !== d8) begin n_bad++; $display("FAIL nb8_identity t=%0d got=%h want=%h", t, w8_out_data, d8); end
      n_cmp++; if (w6_out_data !== d6) begin n_bad++; $display("FAIL nb6_identity t=%0d got=%h want=%h", t, w6_out_data, d6); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_inv = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b1;
    w6_in_data = '0; w8_in_data = '0;
    test_reset();
    test_vectors();
    test_full_rate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
